// File: rtl/riscv_pkg.sv
// Shared types for the RV32I execute stage: ALU opcodes, forwarding selects,
// pipeline register layouts and their bubble values.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // Load/store funct3 slot value meaning "no memory access".
  localparam logic [2:0] TYPE_NONE = 3'b111;

  // {sub/arith bit, funct3}
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_ctrl_e;

  // 2'b11 is reserved and behaves like the regfile path.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_RSV = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [3:0]        alu_control;
    logic [2:0]        typ;
    logic              alu_src;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_write;
  } id_ex_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_write;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   write_data;
    logic [REG_AW-1:0] rd;
    logic [2:0]        typ;
    logic              zero;
    logic              lt;
    logic              ltu;
  } ex_mem_t;

  // Bubble == reset value: all zero except the access type.
  function automatic id_ex_t id_ex_bubble();
    id_ex_t b;
    b     = '0;
    b.typ = TYPE_NONE;
    return b;
  endfunction

  function automatic ex_mem_t ex_mem_bubble();
    ex_mem_t b;
    b     = '0;
    b.typ = TYPE_NONE;
    return b;
  endfunction

endpackage

// File: rtl/alu.sv
// Integer ALU for the execute stage. Purely combinational.
// Unlisted opcodes fall back to add; shifts use only b[4:0].
module alu #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_control,
  output logic [XLEN-1:0] result
);
  import riscv_pkg::*;

  logic [4:0] shamt;
  assign shamt = b[4:0];

  // Opcode decode; arithmetic wraps naturally at XLEN bits.
  always_comb begin
    result = a + b;
    case (alu_control)
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = a + b;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the pipelined RV32I core: ID/EX register, operand
// forwarding, ALU and the registered EX/MEM boundary (ID -> MEM in 2 cycles).
// Build option EX_FORWARD_EN: when undefined the forwarding ports are
// ignored and operands come straight from ID/EX (hazard unit must stall).
module ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [3:0]        id_alu_control,
  input  logic [2:0]        id_type,
  input  logic              id_alu_src,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_write,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic [XLEN-1:0]   wb_fwd_data,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic              mem_valid,
  output logic              mem_reg_write,
  output logic              mem_mem_write,
  output logic [XLEN-1:0]   mem_alu_result,
  output logic [XLEN-1:0]   mem_write_data,
  output logic [REG_AW-1:0] mem_rd,
  output logic [2:0]        mem_type,
  output logic              mem_zero,
  output logic              mem_lt,
  output logic              mem_ltu
);
  import riscv_pkg::*;

  id_ex_t          id_ex_q, id_ex_d;
  ex_mem_t         ex_mem_q, ex_mem_d;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd, op_b, alu_result;

  // No PC-relative op is executed here; pc rides along for later stages.
  logic unused_pc;
  assign unused_pc = ^id_ex_q.pc;

`ifdef EX_FORWARD_EN
  // Operand bypass from MEM/WB; reserved select falls back to the regfile.
  always_comb begin
    rs1_fwd = id_ex_q.rs1_data;
    rs2_fwd = id_ex_q.rs2_data;
    case (fwd_sel_e'(fwd_a))
      FWD_WB:  rs1_fwd = wb_fwd_data;
      FWD_MEM: rs1_fwd = mem_fwd_data;
      default: rs1_fwd = id_ex_q.rs1_data;
    endcase
    case (fwd_sel_e'(fwd_b))
      FWD_WB:  rs2_fwd = wb_fwd_data;
      FWD_MEM: rs2_fwd = mem_fwd_data;
      default: rs2_fwd = id_ex_q.rs2_data;
    endcase
  end
`else
  // No bypass: operands straight from ID/EX, forwarding ports are sunk.
  logic unused_fwd;
  assign unused_fwd = ^{fwd_a, fwd_b, mem_fwd_data, wb_fwd_data};
  always_comb begin
    rs1_fwd = id_ex_q.rs1_data;
    rs2_fwd = id_ex_q.rs2_data;
  end
`endif

  assign op_b = id_ex_q.alu_src ? id_ex_q.imm : rs2_fwd;

  alu #(.XLEN(XLEN)) u_alu (
    .a          (rs1_fwd),
    .b          (op_b),
    .alu_control(id_ex_q.alu_control),
    .result     (alu_result)
  );

  // ID/EX next state: stall holds (beats flush), flush inserts a bubble.
  always_comb begin
    id_ex_d = id_ex_q;
    if (stall) begin
      id_ex_d = id_ex_q;
    end else if (flush) begin
      id_ex_d = id_ex_bubble();
    end else begin
      id_ex_d.valid       = id_valid;
      id_ex_d.alu_control = id_alu_control;
      id_ex_d.typ         = id_type;
      id_ex_d.alu_src     = id_alu_src;
      id_ex_d.rs1_data    = id_rs1_data;
      id_ex_d.rs2_data    = id_rs2_data;
      id_ex_d.imm         = id_imm;
      id_ex_d.pc          = id_pc;
      id_ex_d.rs1         = id_rs1;
      id_ex_d.rs2         = id_rs2;
      id_ex_d.rd          = id_rd;
      id_ex_d.reg_write   = id_reg_write;
      id_ex_d.mem_write   = id_mem_write;
    end
  end

  // EX/MEM next state; an invalid slot can never commit a write.
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (!stall) begin
      ex_mem_d.valid      = id_ex_q.valid;
      ex_mem_d.reg_write  = id_ex_q.valid & id_ex_q.reg_write;
      ex_mem_d.mem_write  = id_ex_q.valid & id_ex_q.mem_write;
      ex_mem_d.alu_result = alu_result;
      ex_mem_d.write_data = rs2_fwd;
      ex_mem_d.rd         = id_ex_q.rd;
      ex_mem_d.typ        = id_ex_q.typ;
      ex_mem_d.zero       = (rs1_fwd == rs2_fwd);
      ex_mem_d.lt         = ($signed(rs1_fwd) < $signed(rs2_fwd));
      ex_mem_d.ltu        = (rs1_fwd < rs2_fwd);
    end
  end

  // Pipeline registers with synchronous reset to bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q  <= id_ex_bubble();
      ex_mem_q <= ex_mem_bubble();
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
    end
  end

  assign ex_rs1         = id_ex_q.rs1;
  assign ex_rs2         = id_ex_q.rs2;
  assign mem_valid      = ex_mem_q.valid;
  assign mem_reg_write  = ex_mem_q.reg_write;
  assign mem_mem_write  = ex_mem_q.mem_write;
  assign mem_alu_result = ex_mem_q.alu_result;
  assign mem_write_data = ex_mem_q.write_data;
  assign mem_rd         = ex_mem_q.rd;
  assign mem_type       = ex_mem_q.typ;
  assign mem_zero       = ex_mem_q.zero;
  assign mem_lt         = ex_mem_q.lt;
  assign mem_ltu        = ex_mem_q.ltu;

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: reset, ALU sweep, flags, forwarding,
// stall, flush and stall+flush ordering.
module tb_ex_stage;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst, stall, flush, id_valid, id_alu_src;
  logic [3:0]        id_alu_control;
  logic [2:0]        id_type;
  logic [XLEN-1:0]   id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_reg_write, id_mem_write;
  logic [1:0]        fwd_a, fwd_b;
  logic [XLEN-1:0]   mem_fwd_data, wb_fwd_data;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, mem_rd;
  logic              mem_valid, mem_reg_write, mem_mem_write;
  logic [XLEN-1:0]   mem_alu_result, mem_write_data;
  logic [2:0]        mem_type;
  logic              mem_zero, mem_lt, mem_ltu;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_alu_control(id_alu_control), .id_type(id_type),
    .id_alu_src(id_alu_src), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_write(id_mem_write),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_valid(mem_valid),
    .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
    .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
    .mem_rd(mem_rd), .mem_type(mem_type), .mem_zero(mem_zero),
    .mem_lt(mem_lt), .mem_ltu(mem_ltu)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One clock, then settle at the falling edge for driving and sampling.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic [3:0] ctl, input logic [2:0] typ,
                        input logic src, input logic [31:0] r1d, input logic [31:0] r2d,
                        input logic [31:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic rw, input logic mw);
    id_valid = v; id_alu_control = ctl; id_type = typ; id_alu_src = src;
    id_rs1_data = r1d; id_rs2_data = r2d; id_imm = imm;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_reg_write = rw; id_mem_write = mw;
  endtask

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t sweep[11];

  initial begin
    sweep[0]  = '{4'b0000, 32'h8000_0005}; // add
    sweep[1]  = '{4'b1000, 32'h8000_0003}; // sub
    sweep[2]  = '{4'b0001, 32'h0000_0008}; // sll, bit 31 shifted out
    sweep[3]  = '{4'b0010, 32'h0000_0001}; // slt: negative < 1
    sweep[4]  = '{4'b0011, 32'h0000_0000}; // sltu
    sweep[5]  = '{4'b0100, 32'h8000_0005}; // xor
    sweep[6]  = '{4'b0101, 32'h4000_0002}; // srl
    sweep[7]  = '{4'b1101, 32'hC000_0002}; // sra
    sweep[8]  = '{4'b0110, 32'h8000_0005}; // or
    sweep[9]  = '{4'b0111, 32'h0000_0000}; // and
    sweep[10] = '{4'b1001, 32'h8000_0005}; // unlisted -> add

    rst = 1'b1; stall = 1'b0; flush = 1'b0; id_pc = 32'h100;
    fwd_a = 2'b00; fwd_b = 2'b00; mem_fwd_data = 32'h0; wb_fwd_data = 32'h0;
    set_id(1'b1, 4'b0000, 3'b010, 1'b0, 32'hAAAA, 32'h5555, 32'h0, 5'd9, 5'd10, 5'd11, 1'b1, 1'b1);
    @(negedge clk);
    tick(); tick();
    chk("rst_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_type", {29'b0, mem_type}, 32'd7);
    chk("rst_rw", {31'b0, mem_reg_write}, 32'd0);
    chk("rst_mw", {31'b0, mem_mem_write}, 32'd0);
    chk("rst_result", mem_alu_result, 32'd0);
    chk("rst_ex_rs1", {27'b0, ex_rs1}, 32'd0);
    rst = 1'b0;

    // ALU sweep, inputs held for two edges so ID reaches MEM.
    for (int i = 0; i < 11; i++) begin
      set_id(1'b1, sweep[i].ctl, 3'b111, 1'b0, 32'h8000_0004, 32'h0000_0001, 32'h0,
             5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
      tick(); tick();
      chk($sformatf("alu_%b", sweep[i].ctl), mem_alu_result, sweep[i].exp);
    end
    chk("flag_zero", {31'b0, mem_zero}, 32'd0);
    chk("flag_lt", {31'b0, mem_lt}, 32'd1);
    chk("flag_ltu", {31'b0, mem_ltu}, 32'd0);
    chk("wdata", mem_write_data, 32'h1);
    chk("rd_pass", {27'b0, mem_rd}, 32'd3);

    // Immediate operand: only imm[4:0]=3 sets the shift.
    set_id(1'b1, 4'b0001, 3'b000, 1'b1, 32'h8000_0004, 32'h1, 32'hFFFF_FFE3,
           5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
    tick(); tick();
    chk("sll_imm", mem_alu_result, 32'h0000_0020);
    chk("type_pass", {29'b0, mem_type}, 32'd0);
    chk("rd0_rw", {31'b0, mem_reg_write}, 32'd1);
    set_id(1'b1, 4'b1101, 3'b111, 1'b1, 32'h8000_0000, 32'h1, 32'h0000_0104,
           5'd1, 5'd2, 5'd4, 1'b1, 1'b0);
    tick(); tick();
    chk("sra_imm", mem_alu_result, 32'hF800_0000);

    // Flag boundaries.
    set_id(1'b1, 4'b0000, 3'b111, 1'b0, 32'h5, 32'h5, 32'h0, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0);
    tick(); tick();
    chk("eq_zero", {31'b0, mem_zero}, 32'd1);
    chk("eq_lt", {31'b0, mem_lt}, 32'd0);
    chk("eq_ltu", {31'b0, mem_ltu}, 32'd0);
    set_id(1'b1, 4'b0000, 3'b111, 1'b0, 32'h1, 32'hFFFF_FFFF, 32'h0, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0);
    tick(); tick();
    chk("neg_lt", {31'b0, mem_lt}, 32'd0);
    chk("neg_ltu", {31'b0, mem_ltu}, 32'd1);
    chk("wrap_add", mem_alu_result, 32'h0);

    // Forwarding.
    set_id(1'b1, 4'b0000, 3'b111, 1'b0, 32'd100, 32'd200, 32'h0, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0);
    fwd_a = 2'b10; mem_fwd_data = 32'd5; fwd_b = 2'b01; wb_fwd_data = 32'd7;
    tick(); tick();
`ifdef EX_FORWARD_EN
    chk("fwd_sum", mem_alu_result, 32'd12);
    chk("fwd_wdata", mem_write_data, 32'd7);
`else
    chk("nofwd_sum", mem_alu_result, 32'd300);
    chk("nofwd_wdata", mem_write_data, 32'd200);
`endif
    fwd_a = 2'b11; fwd_b = 2'b00;
    tick(); tick();
    chk("fwd_rsv", mem_alu_result, 32'd300);
    fwd_a = 2'b00;

    // Invalid slot must not commit writes.
    set_id(1'b0, 4'b0000, 3'b010, 1'b0, 32'd1, 32'd1, 32'h0, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
    tick(); tick();
    chk("inv_valid", {31'b0, mem_valid}, 32'd0);
    chk("inv_rw", {31'b0, mem_reg_write}, 32'd0);
    chk("inv_mw", {31'b0, mem_mem_write}, 32'd0);

    // Stall: A, B issued, stall 3 cycles while C waits in ID.
    set_id(1'b1, 4'b0000, 3'b111, 1'b0, 32'd10, 32'd1, 32'h0, 5'd11, 5'd12, 5'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'b0000, 3'b111, 1'b0, 32'd20, 32'd1, 32'h0, 5'd21, 5'd22, 5'd2, 1'b1, 1'b0);
    tick();
    chk("pre_stall_rd", {27'b0, mem_rd}, 32'd1);
    set_id(1'b1, 4'b0000, 3'b111, 1'b0, 32'd30, 32'd1, 32'h0, 5'd31, 5'd30, 5'd3, 1'b1, 1'b0);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_rd", {27'b0, mem_rd}, 32'd1);
      chk("stall_res", mem_alu_result, 32'd11);
      chk("stall_ex_rs1", {27'b0, ex_rs1}, 32'd21);
      chk("stall_ex_rs2", {27'b0, ex_rs2}, 32'd22);
    end
    stall = 1'b0;
    tick();
    chk("rel_rd", {27'b0, mem_rd}, 32'd2);
    chk("rel_res", mem_alu_result, 32'd21);
    tick();
    chk("rel_next_rd", {27'b0, mem_rd}, 32'd3);

    // Flush turns a writing load/store into a bubble.
    set_id(1'b1, 4'b0000, 3'b010, 1'b0, 32'd1, 32'd2, 32'h0, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_id(1'b0, 4'b0000, 3'b111, 1'b0, 32'd0, 32'd0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("fl_valid", {31'b0, mem_valid}, 32'd0);
    chk("fl_rw", {31'b0, mem_reg_write}, 32'd0);
    chk("fl_mw", {31'b0, mem_mem_write}, 32'd0);
    chk("fl_type", {29'b0, mem_type}, 32'd7);

    // Stall+flush holds, then flush alone bubbles; E and F each appear once.
    set_id(1'b1, 4'b0000, 3'b111, 1'b0, 32'd50, 32'd0, 32'h0, 5'd5, 5'd6, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'b0000, 3'b111, 1'b0, 32'd60, 32'd0, 32'h0, 5'd8, 5'd9, 5'd6, 1'b1, 1'b0);
    stall = 1'b1; flush = 1'b1;
    tick();
    chk("sf_hold_rs1", {27'b0, ex_rs1}, 32'd5);
    chk("sf_hold_valid", {31'b0, mem_valid}, 32'd0);
    stall = 1'b0;
    tick();
    chk("sf_e_rd", {27'b0, mem_rd}, 32'd5);
    chk("sf_e_res", mem_alu_result, 32'd50);
    chk("sf_bubble_rs1", {27'b0, ex_rs1}, 32'd0);
    flush = 1'b0;
    tick();
    chk("sf_bubble", {31'b0, mem_valid}, 32'd0);
    chk("sf_f_rs1", {27'b0, ex_rs1}, 32'd8);
    set_id(1'b0, 4'b0000, 3'b111, 1'b0, 32'd0, 32'd0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("sf_f_rd", {27'b0, mem_rd}, 32'd6);
    chk("sf_f_valid", {31'b0, mem_valid}, 32'd1);
    chk("sf_f_res", mem_alu_result, 32'd60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the pipelined RV32I core.
- Directly downstream of instruction decode; consumes the decoder's 4-bit ALU control and 3-bit access type.
- Holds the ID/EX register, operand forwarding muxes and the integer ALU, and drives the registered EX/MEM boundary.
- ID inputs reach MEM outputs in 2 cycles.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- stall  in  1  freeze ID/EX and EX/MEM (memory wait).
- flush  in  1  load bubble into ID/EX (load-use or taken branch).
- id_valid  in  1  ID slot holds a real instruction.
- id_alu_control  in  4  {sub/arith bit, funct3}.
- id_type  in  3  load/store funct3; 3'b111 = no memory access.
- id_alu_src  in  1  1 selects id_imm as operand B.
- id_rs1_data, id_rs2_data, id_imm, id_pc  in  XLEN  decoded operands.
- id_rs1, id_rs2, id_rd  in  REG_AW  register indices.
- id_reg_write, id_mem_write  in  1  control.
- fwd_a, fwd_b  in  2  00 regfile, 01 WB, 10 MEM, 11 reserved (treated as 00).
- mem_fwd_data, wb_fwd_data  in  XLEN  forwarding sources.
- ex_rs1, ex_rs2  out  REG_AW  ID/EX indices for the hazard unit.
- mem_valid, mem_reg_write, mem_mem_write  out  1.
- mem_alu_result, mem_write_data  out  XLEN.
- mem_rd  out  REG_AW.
- mem_type  out  3.
- mem_zero, mem_lt, mem_ltu  out  1  branch flags on forwarded rs1 vs rs2.

Behaviour:
- Reset: every ID/EX and EX/MEM field clears to 0, except both type fields, which reset to 3'b111. Bubble = reset value.
- ID/EX update priority:
  - rst, then
  - stall (hold), then
  - flush (bubble), then
  - load ID inputs.
  - stall and flush together: stall wins; the hazard unit reasserts flush.
- EX/MEM update: rst, then stall (hold), else load EX results.
- A bubble (valid=0) forces reg_write=0 and mem_write=0 into EX/MEM regardless of field contents.
- Operand A = fwd_a-selected rs1. Forwarded rs2 = fwd_b-selected rs2; this also drives mem_write_data. Operand B = id_alu_src ? imm : forwarded rs2.
- ALU codes:
  - 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu.
  - 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and.
  - Any other code gives the add result.
- Shifts use B[4:0] only. Arithmetic wraps mod 2^XLEN; no overflow flag.
- Flags always compare forwarded rs1 and rs2, independent of ALU op:
  - zero = equal.
  - lt = signed less-than.
  - ltu = unsigned less-than.
- mem_type and mem_rd pass through unchanged.
- rd == 0: passes through with reg_write as given; the regfile ignores writes to x0.

Optional Feature:
- Macro EX_FORWARD_EN.
- Defined: forwarding muxes as above.
- Undefined:
  - fwd_a, fwd_b, mem_fwd_data and wb_fwd_data are ignored.
  - Operands come straight from ID/EX.
  - The hazard unit must stall on every RAW hazard.
- Ports exist in both builds.

Decomposition:
- Package riscv_pkg holds:
  - alu_ctrl_e enum (the ten codes above).
  - TYPE_NONE = 3'b111.
  - fwd_sel_e enum.
  - id_ex_t and ex_mem_t structs.
- One sub-module: alu (purely combinational: a, b, alu_control in; result out).
- ex_stage owns the registers, muxes and flags.

Test Plan:
- Reset: hold rst 2 cycles -> mem_valid=0, mem_type=3'b111, mem_reg_write=0, mem_alu_result=0.
- ALU sweep: rs1=0x8000_0004, rs2=0x0000_0001, alu_src=0, each code -> after 2 cycles:
  - sub=0x8000_0003.
  - sra=0xC000_0002, srl=0x4000_0002.
  - slt=1, sltu=0.
  - zero=0, lt=1, ltu=0.
- Forwarding: fwd_a=10, mem_fwd_data=5, fwd_b=01, wb_fwd_data=7, alu_control 0000 -> result 12. With EX_FORWARD_EN undefined, the same stimulus yields rs1_data+rs2_data.
- Stall: assert stall for 3 cycles mid-stream -> mem_* outputs and ex_rs1/ex_rs2 unchanged; the next instruction appears 1 cycle after release.
- Flush: flush with id_reg_write=1, id_mem_write=1 -> next EX/MEM has valid=0, reg_write=0, mem_write=0, type=3'b111.
- Stall+flush together, then flush alone -> first cycle holds; second cycle inserts bubble; no instruction is duplicated or lost.
